// File: rtl/video_scan_doubler_pkg.sv
// Shared constants and output-FSM state encoding for the VGA line doubler.
package video_scan_doubler_pkg;

    localparam int VGA_LINE_PIXELS  = 1024;
    localparam int VGA_HSYNC_CYCLES = 256;
    localparam int VGA_PERIOD_W     = 13;

    typedef enum logic [2:0] {
        SD_IDLE,
        SD_PASS0,
        SD_GAP0,
        SD_PASS1,
        SD_GAP1
    } sd_state_t;

endpackage

// File: rtl/video_scan_doubler_line_buffer.sv
// Ping-pong line store: two banks of 1-bit pixels, one write port and one registered read port.
module video_line_buffer #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clock_i,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data,
    input  logic          rd_en,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_data
);

    logic mem [0:2*DEPTH-1];

    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    always_ff @(posedge clock_i) begin
        if (rd_en) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/video_scan_doubler.sv
// Line doubler: captures each 15.6 kHz source line and replays it twice at 2x pixel rate.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   SD_IDLE  | source timing not locked, outputs held low
//   SD_PASS0 | first replay of the last captured line
//   SD_GAP0  | waiting for half of the previous source line period
//   SD_PASS1 | second replay of the same line
//   SD_GAP1  | waiting for the next source h-sync edge
module video_scan_doubler
    import video_scan_doubler_pkg::*;
#(
    parameter int LINE_PIXELS  = VGA_LINE_PIXELS,
    parameter int PERIOD_W     = VGA_PERIOD_W,
    parameter int HSYNC_CYCLES = VGA_HSYNC_CYCLES
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic pixel_clk_en_i,
    input  logic dbl_clk_en_i,
    input  logic video_i,
    input  logic h_sync_i,
    input  logic v_sync_i,
    output logic vga_video_o,
    output logic vga_h_sync_o,
    output logic vga_v_sync_o,
    output logic vga_de_o,
    output logic line_valid_o
);

    localparam int AW = $clog2(LINE_PIXELS);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HSYNC_CYCLES + 1);
    localparam logic [CW-1:0]       LINE_FULL  = CW'(LINE_PIXELS);
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
    localparam logic [HW-1:0]       HS_LOAD    = HW'(HSYNC_CYCLES);

    logic                h_sync_q;
    logic                hs_edge;
    logic                wr_bank;
    logic [CW-1:0]       wr_addr;
    logic [CW-1:0]       rd_len;
    logic [CW-1:0]       rd_addr;
    logic [PERIOD_W-1:0] period_cnt;
    logic [PERIOD_W-1:0] half;
    logic [PERIOD_W-1:0] out_cnt;
    logic                period_sat;
    logic                seen_edge;
    logic                seen_nx;
    logic                line_valid;
    logic                valid_nx;
    sd_state_t           state;
    sd_state_t           state_nx;
    logic                pass_start;
    logic                in_pass;
    logic                rd_more;
    logic                rd_en;
    logic                rd_done;
    logic [HW-1:0]       hs_cnt;
    logic                v_sync_q;
    logic                de_q;
    logic                wr_en;
    logic                wr_bank_sel;
    logic [AW-1:0]       wr_addr_sel;
    logic                rd_data;

    assign hs_edge    = h_sync_i & ~h_sync_q;
    assign period_sat = (period_cnt == PERIOD_MAX);

    // Lock needs one full measured period: first edge arms, second edge validates.
    always_comb begin
        seen_nx  = seen_edge;
        valid_nx = line_valid;
        if (hs_edge) begin
            seen_nx  = 1'b1;
            valid_nx = seen_edge & ~period_sat;
        end else if (period_sat) begin
            seen_nx  = 1'b0;
            valid_nx = 1'b0;
        end
    end

    // The edge pixel belongs to the new line, so it goes to address 0 of the new bank.
    assign wr_en       = pixel_clk_en_i & (hs_edge | (wr_addr != LINE_FULL));
    assign wr_bank_sel = hs_edge ? ~wr_bank : wr_bank;
    assign wr_addr_sel = hs_edge ? '0 : wr_addr[AW-1:0];

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            h_sync_q   <= 1'b0;
            wr_bank    <= 1'b0;
            wr_addr    <= '0;
            rd_len     <= '0;
            period_cnt <= '0;
            half       <= '0;
            seen_edge  <= 1'b0;
            line_valid <= 1'b0;
        end else begin
            h_sync_q   <= h_sync_i;
            seen_edge  <= seen_nx;
            line_valid <= valid_nx;
            if (hs_edge) begin
                wr_bank    <= ~wr_bank;
                rd_len     <= wr_addr;
                half       <= period_cnt >> 1;
                period_cnt <= '0;
                wr_addr    <= pixel_clk_en_i ? CW'(1) : '0;
            end else begin
                if (!period_sat) begin
                    period_cnt <= period_cnt + 1'b1;
                end
                if (wr_en) begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
        end
    end

    assign in_pass = (state == SD_PASS0) || (state == SD_PASS1);
    assign rd_more = (rd_addr != rd_len);
    assign rd_en   = in_pass & dbl_clk_en_i & rd_more & ~pass_start;
    assign rd_done = in_pass & dbl_clk_en_i & ~rd_more;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= SD_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Any source edge restarts at PASS0, even if a previous pass is still running.
    always_comb begin
        state_nx   = state;
        pass_start = 1'b0;
        if (!valid_nx) begin
            state_nx = SD_IDLE;
        end else if (hs_edge) begin
            state_nx   = SD_PASS0;
            pass_start = 1'b1;
        end else begin
            case (state)
                SD_PASS0: if (rd_done) state_nx = SD_GAP0;
                SD_GAP0: begin
                    if (out_cnt >= half) begin
                        state_nx   = SD_PASS1;
                        pass_start = 1'b1;
                    end
                end
                SD_PASS1: if (rd_done) state_nx = SD_GAP1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_cnt  <= '0;
            rd_addr  <= '0;
            hs_cnt   <= '0;
            v_sync_q <= 1'b0;
            de_q     <= 1'b0;
        end else if (!valid_nx) begin
            out_cnt  <= '0;
            rd_addr  <= '0;
            hs_cnt   <= '0;
            v_sync_q <= 1'b0;
            de_q     <= 1'b0;
        end else begin
            if (hs_edge) begin
                out_cnt <= '0;
            end else if (out_cnt != PERIOD_MAX) begin
                out_cnt <= out_cnt + 1'b1;
            end
            if (pass_start) begin
                rd_addr  <= '0;
                hs_cnt   <= HS_LOAD;
                v_sync_q <= v_sync_i;
                de_q     <= 1'b0;
            end else begin
                if (hs_cnt != '0) begin
                    hs_cnt <= hs_cnt - 1'b1;
                end
                if (rd_en) begin
                    rd_addr <= rd_addr + 1'b1;
                    de_q    <= 1'b1;
                end else if (rd_done) begin
                    de_q <= 1'b0;
                end
            end
        end
    end

    video_line_buffer #(
        .DEPTH (LINE_PIXELS),
        .AW    (AW)
    ) u_line_buffer (
        .clock_i (clock_i),
        .wr_en   (wr_en),
        .wr_bank (wr_bank_sel),
        .wr_addr (wr_addr_sel),
        .wr_data (video_i),
        .rd_en   (rd_en),
        .rd_bank (~wr_bank),
        .rd_addr (rd_addr[AW-1:0]),
        .rd_data (rd_data)
    );

    // Read data register is not reset; de_q masks it outside a pass.
    assign vga_video_o  = rd_data & de_q;
    assign vga_h_sync_o = (hs_cnt != '0);
    assign vga_v_sync_o = v_sync_q;
    assign vga_de_o     = de_q;
    assign line_valid_o = line_valid;

endmodule
